// File: rtl/ip_pkg.sv
// Shared IPv4 definitions: parser states, reject reasons, protocol numbers and
// the one's-complement adder also used by the TCP checksum logic.
package ip_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HDR     = 3'd1,
    S_OPT     = 3'd2,
    S_PAYLOAD = 3'd3,
    S_DROP    = 3'd4
  } state_t;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_VERSION = 3'd1;
  localparam logic [2:0] ERR_IHL     = 3'd2;
  localparam logic [2:0] ERR_PROTO   = 3'd3;
  localparam logic [2:0] ERR_CSUM    = 3'd4;
  localparam logic [2:0] ERR_TLEN    = 3'd5;
  localparam logic [2:0] ERR_TRUNC   = 3'd6;
  localparam logic [2:0] ERR_DA      = 3'd7;

  localparam logic [7:0] IP_PROTO_ICMP = 8'd1;
  localparam logic [7:0] IP_PROTO_TCP  = 8'd6;
  localparam logic [7:0] IP_PROTO_UDP  = 8'd17;

  function automatic logic [15:0] ones_comp_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

endpackage

// File: rtl/ipv4_csum_acc.sv
// Byte-serial one's-complement checksum accumulator; pairs bytes big-endian.
// o_sum/o_good already include the byte strobed this cycle.
module ipv4_csum_acc
  import ip_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic        i_stb,
  input  logic [7:0]  i_byte,
  output logic [15:0] o_sum,
  output logic        o_good
);

  logic [15:0] r_sum;
  logic [7:0]  r_hi;
  logic        r_odd;
  logic [15:0] w_base;
  logic        w_odd;

  // A clear coinciding with a strobe makes that byte the first of a new sum.
  always_comb begin
    w_base = i_clr ? '0 : r_sum;
    w_odd  = i_clr ? 1'b0 : r_odd;
    o_sum  = (i_stb && w_odd) ? ones_comp_add(w_base, {r_hi, i_byte}) : w_base;
    o_good = (o_sum == 16'hFFFF);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum <= '0;
      r_hi  <= '0;
      r_odd <= 1'b0;
    end else begin
      r_sum <= o_sum;
      if (i_stb) begin
        r_odd <= ~w_odd;
        if (!w_odd) r_hi <= i_byte;
      end else begin
        r_odd <= w_odd;
      end
    end
  end

endmodule

// File: rtl/ipv4_rx_parser.sv
// IPv4 receive parser: validates the header, skips options, frames the payload.
// Define IPV4_DA_FILTER_EN to add the local_ip port and destination filtering.
module ipv4_rx_parser
  import ip_pkg::*;
#(
  parameter int ACCEPT_TCP  = 1,
  parameter int ACCEPT_UDP  = 1,
  parameter int ACCEPT_ICMP = 0,
  parameter int MAX_IHL     = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic [7:0]  din,
  output logic [31:0] sa,
  output logic [31:0] da,
  output logic [7:0]  proto,
  output logic [15:0] payload_len,
  output logic        hdr_done,
  output logic        err,
  output logic [2:0]  err_code,
  output logic        pl_valid,
  output logic [7:0]  pl_data,
  output logic        pl_last
`ifdef IPV4_DA_FILTER_EN
  ,
  input  logic [31:0] local_ip
`endif
);

  state_t      r_state;
  logic [15:0] r_idx;
  logic [15:0] r_tl;
  logic [3:0]  r_ihl;
  logic [7:0]  r_proto_w;
  logic [31:0] r_sa_w;
  logic [31:0] r_da_w;

  logic [15:0] w_hdr_len;
  logic [15:0] w_hdr_last;
  logic [15:0] w_tl_now;
  logic [31:0] w_da_now;
  logic [15:0] w_csum_sum;
  logic        w_csum_good;
  logic        w_csum_clr;
  logic        w_csum_stb;
  logic        w_unused_sum;
  logic        w_fail;
  logic [2:0]  w_code;

  function automatic logic proto_ok(input logic [7:0] p);
    return (p == IP_PROTO_TCP  && ACCEPT_TCP  != 0) ||
           (p == IP_PROTO_UDP  && ACCEPT_UDP  != 0) ||
           (p == IP_PROTO_ICMP && ACCEPT_ICMP != 0);
  endfunction

  assign w_hdr_len    = {10'd0, r_ihl, 2'b00};
  assign w_hdr_last   = w_hdr_len - 16'd1;
  assign w_tl_now     = {r_tl[15:8], din};
  assign w_da_now     = (r_state == S_HDR) ? {r_da_w[23:0], din} : r_da_w;
  assign w_csum_clr   = (r_state == S_IDLE);
  assign w_csum_stb   = valid && (r_state inside {S_IDLE, S_HDR, S_OPT});
  assign w_unused_sum = ^w_csum_sum;

  ipv4_csum_acc u_csum (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_csum_clr),
    .i_stb  (w_csum_stb),
    .i_byte (din),
    .o_sum  (w_csum_sum),
    .o_good (w_csum_good)
  );

  // Per-byte header checks; each fires only on the byte that completes its field.
  always_comb begin
    w_fail = 1'b0;
    w_code = ERR_NONE;
    case (r_state)
      S_IDLE: begin
        if (din[7:4] != 4'd4) begin
          w_fail = 1'b1;
          w_code = ERR_VERSION;
        end else if (din[3:0] < 4'd5 || din[3:0] > 4'(MAX_IHL)) begin
          w_fail = 1'b1;
          w_code = ERR_IHL;
        end
      end
      S_HDR, S_OPT: begin
        if (r_state == S_HDR && r_idx == 16'd3 && w_tl_now < w_hdr_len) begin
          w_fail = 1'b1;
          w_code = ERR_TLEN;
        end else if (r_state == S_HDR && r_idx == 16'd9 && !proto_ok(din)) begin
          w_fail = 1'b1;
          w_code = ERR_PROTO;
        end else if (r_idx == w_hdr_last && !w_csum_good) begin
          w_fail = 1'b1;
          w_code = ERR_CSUM;
        end
`ifdef IPV4_DA_FILTER_EN
        else if (r_state == S_HDR && r_idx == 16'd19 &&
                 w_da_now != local_ip && w_da_now != 32'hFFFF_FFFF) begin
          w_fail = 1'b1;
          w_code = ERR_DA;
        end
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_tl        <= '0;
      r_ihl       <= '0;
      r_proto_w   <= '0;
      r_sa_w      <= '0;
      r_da_w      <= '0;
      sa          <= '0;
      da          <= '0;
      proto       <= '0;
      payload_len <= '0;
      hdr_done    <= 1'b0;
      err         <= 1'b0;
      err_code    <= ERR_NONE;
      pl_valid    <= 1'b0;
      pl_data     <= '0;
      pl_last     <= 1'b0;
    end else begin
      hdr_done <= 1'b0;
      pl_valid <= 1'b0;
      pl_last  <= 1'b0;
      if (!valid) begin
        r_state <= S_IDLE;
        r_idx   <= '0;
        // Frame ended before total_length: single-cycle truncation report.
        if (r_state inside {S_HDR, S_OPT, S_PAYLOAD}) begin
          err      <= 1'b1;
          err_code <= ERR_TRUNC;
        end else begin
          err      <= 1'b0;
          err_code <= ERR_NONE;
        end
      end else begin
        if (r_idx != 16'hFFFF) r_idx <= r_idx + 16'd1;
        if (r_state == S_IDLE) begin
          r_ihl    <= din[3:0];
          err      <= 1'b0;
          err_code <= ERR_NONE;
        end
        if (r_state == S_HDR) begin
          case (r_idx)
            16'd2:                      r_tl[15:8] <= din;
            16'd3:                      r_tl[7:0]  <= din;
            16'd9:                      r_proto_w  <= din;
            16'd12, 16'd13, 16'd14, 16'd15: r_sa_w <= {r_sa_w[23:0], din};
            16'd16, 16'd17, 16'd18, 16'd19: r_da_w <= {r_da_w[23:0], din};
            default: ;
          endcase
        end
        if (w_fail) begin
          r_state  <= S_DROP;
          err      <= 1'b1;
          err_code <= w_code;
        end else begin
          case (r_state)
            S_IDLE: r_state <= S_HDR;
            S_HDR, S_OPT: begin
              if (r_idx == w_hdr_last) begin
                hdr_done    <= 1'b1;
                sa          <= r_sa_w;
                da          <= w_da_now;
                proto       <= r_proto_w;
                payload_len <= r_tl - w_hdr_len;
                r_state     <= (r_tl == w_hdr_len) ? S_DROP : S_PAYLOAD;
              end else if (r_idx == 16'd19) begin
                r_state <= S_OPT;
              end
            end
            S_PAYLOAD: begin
              pl_valid <= 1'b1;
              pl_data  <= din;
              if (r_idx == r_tl - 16'd1) begin
                pl_last <= 1'b1;
                r_state <= S_DROP;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_ipv4_rx_parser.sv
// Directed bench for ipv4_rx_parser; covers IPV4_DA_FILTER_EN when it is defined.
module tb_ipv4_rx_parser;

  logic        clk;
  logic        rst;
  logic        valid;
  logic [7:0]  din;
  logic [31:0] sa;
  logic [31:0] da;
  logic [7:0]  proto;
  logic [15:0] payload_len;
  logic        hdr_done;
  logic        err;
  logic [2:0]  err_code;
  logic        pl_valid;
  logic [7:0]  pl_data;
  logic        pl_last;
`ifdef IPV4_DA_FILTER_EN
  logic [31:0] local_ip;
`endif

  ipv4_rx_parser #(
    .ACCEPT_TCP  (1),
    .ACCEPT_UDP  (0),
    .ACCEPT_ICMP (0),
    .MAX_IHL     (15)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .valid       (valid),
    .din         (din),
    .sa          (sa),
    .da          (da),
    .proto       (proto),
    .payload_len (payload_len),
    .hdr_done    (hdr_done),
    .err         (err),
    .err_code    (err_code),
    .pl_valid    (pl_valid),
    .pl_data     (pl_data),
    .pl_last     (pl_last)
`ifdef IPV4_DA_FILTER_EN
    ,
    .local_ip    (local_ip)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [7:0] fr [0:127];
  logic [7:0] pl_buf [0:1023];
  int n_hdr = 0, n_pl = 0, n_last = 0, n_err = 0, last_at = 0;
  logic [2:0] code_seen = '0;
  int b_hdr, b_pl, b_last, b_err;

  always @(negedge clk) begin
    if (hdr_done) n_hdr++;
    if (pl_valid) begin
      pl_buf[n_pl % 1024] = pl_data;
      n_pl++;
      if (pl_last) begin
        n_last++;
        last_at = n_pl;
      end
    end
    if (err) begin
      n_err++;
      code_seen = err_code;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_hdr = n_hdr; b_pl = n_pl; b_last = n_last; b_err = n_err;
  endtask

  task automatic make_hdr(input logic [3:0] ihl, input logic [15:0] tl, input logic [7:0] pr,
                          input logic [31:0] s, input logic [31:0] d);
    logic [16:0] acc;
    int unsigned hl;
    hl = 4 * int'(ihl);
    fr[0]  = {4'h4, ihl};  fr[1]  = 8'h00;
    fr[2]  = tl[15:8];     fr[3]  = tl[7:0];
    fr[4]  = 8'h00;        fr[5]  = 8'h00;
    fr[6]  = 8'h40;        fr[7]  = 8'h00;
    fr[8]  = 8'h40;        fr[9]  = pr;
    fr[10] = 8'h00;        fr[11] = 8'h00;
    fr[12] = s[31:24]; fr[13] = s[23:16]; fr[14] = s[15:8]; fr[15] = s[7:0];
    fr[16] = d[31:24]; fr[17] = d[23:16]; fr[18] = d[15:8]; fr[19] = d[7:0];
    for (int unsigned i = 20; i < hl; i++) fr[i] = 8'h01;
    acc = '0;
    for (int unsigned i = 0; i < hl; i += 2) begin
      acc = {1'b0, acc[15:0]} + {1'b0, fr[i], fr[i+1]};
      acc = {1'b0, acc[15:0]} + {16'd0, acc[16]};
    end
    fr[10] = ~acc[15:8];
    fr[11] = ~acc[7:0];
  endtask

  task automatic fill(input int unsigned start, input int unsigned n, input logic [7:0] base);
    for (int unsigned i = 0; i < n; i++) fr[start + i] = base + 8'(i);
  endtask

  task automatic send(input int unsigned n, input int unsigned idle);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      valid = 1'b1;
      din   = fr[i];
    end
    for (int unsigned i = 0; i < idle; i++) begin
      @(negedge clk);
      valid = 1'b0;
      din   = '0;
    end
  endtask

  initial begin
    rst   = 1'b1;
    valid = 1'b0;
    din   = '0;
`ifdef IPV4_DA_FILTER_EN
    local_ip = 32'hC0A8_0101;
`endif
    repeat (3) @(negedge clk);
    check("rst_sa", sa, 32'h0);
    check("rst_da", da, 32'h0);
    check("rst_proto_len", {proto, payload_len}, 32'h0);
    check("rst_flags", {hdr_done, err, err_code, pl_valid, pl_data, pl_last}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // 1: IHL=5 TCP, 20 payload bytes + 6 pad bytes
    make_hdr(4'd5, 16'h0028, 8'h06, 32'hC0A8_0102, 32'hC0A8_0101);
    fill(20, 20, 8'h80);
    fill(40, 6, 8'hEE);
    snap();
    send(46, 3);
    check("t1_hdr_done", n_hdr - b_hdr, 1);
    check("t1_sa", sa, 32'hC0A8_0102);
    check("t1_da", da, 32'hC0A8_0101);
    check("t1_proto", proto, 8'h06);
    check("t1_payload_len", payload_len, 16'd20);
    check("t1_pl_count", n_pl - b_pl, 20);
    check("t1_pl_last_pos", (n_last - b_last == 1) ? last_at - b_pl : -1, 20);
    check("t1_pl_first", pl_buf[b_pl % 1024], 8'h80);
    check("t1_pl_final", pl_buf[(b_pl + 19) % 1024], 8'h93);
    check("t1_no_err", n_err - b_err, 0);

    // 2: corrupted checksum
    make_hdr(4'd5, 16'h0028, 8'h06, 32'hC0A8_0102, 32'hC0A8_0101);
    fr[10] = fr[10] ^ 8'h01;
    fill(20, 20, 8'h80);
    snap();
    send(40, 3);
    check("t2_err_seen", (n_err - b_err) > 0, 1);
    check("t2_err_code", code_seen, 3'd4);
    check("t2_no_hdr_done", n_hdr - b_hdr, 0);
    check("t2_no_pl", n_pl - b_pl, 0);
    check("t2_err_cleared", err, 1'b0);

    // 3: IHL=7 with 8 option bytes, total_length 36
    make_hdr(4'd7, 16'h0024, 8'h06, 32'h0A00_0001, 32'h0A00_0002);
    fill(28, 8, 8'h30);
    snap();
    send(36, 3);
    check("t3_hdr_done", n_hdr - b_hdr, 1);
    check("t3_payload_len", payload_len, 16'd8);
    check("t3_sa", sa, 32'h0A00_0001);
    check("t3_pl_count", n_pl - b_pl, 8);
    check("t3_pl_first", pl_buf[b_pl % 1024], 8'h30);
    check("t3_pl_last", (n_last - b_last == 1) ? last_at - b_pl : -1, 8);

    // 4a: version 6
    make_hdr(4'd5, 16'h0028, 8'h06, 32'hC0A8_0102, 32'hC0A8_0101);
    fr[0] = 8'h65;
    snap();
    send(20, 3);
    check("t4a_err_code", code_seen, 3'd1);
    check("t4a_err_seen", (n_err - b_err) > 0, 1);
    check("t4a_err_cleared", err, 1'b0);

    // 4b: UDP while UDP is not accepted
    make_hdr(4'd5, 16'h0028, 8'h11, 32'hC0A8_0102, 32'hC0A8_0101);
    snap();
    send(40, 3);
    check("t4b_err_code", code_seen, 3'd3);
    check("t4b_no_hdr_done", n_hdr - b_hdr, 0);
    check("t4b_err_cleared", err, 1'b0);

    // 4c: IHL below 5
    make_hdr(4'd5, 16'h0028, 8'h06, 32'hC0A8_0102, 32'hC0A8_0101);
    fr[0] = 8'h44;
    snap();
    send(20, 3);
    check("t4c_err_code", code_seen, 3'd2);

    // 4d: total_length shorter than header
    make_hdr(4'd5, 16'h0010, 8'h06, 32'hC0A8_0102, 32'hC0A8_0101);
    snap();
    send(20, 3);
    check("t4d_err_code", code_seen, 3'd5);
    check("t4d_no_hdr_done", n_hdr - b_hdr, 0);

    // 5: truncation after 10 payload bytes, then a good frame after one idle cycle
    make_hdr(4'd5, 16'h0028, 8'h06, 32'hC0A8_0102, 32'hC0A8_0101);
    fill(20, 20, 8'h80);
    snap();
    send(30, 1);
    fill(20, 20, 8'hA0);
    send(40, 3);
    check("t5_err_cycles", n_err - b_err, 1);
    check("t5_err_code", code_seen, 3'd6);
    check("t5_hdr_done", n_hdr - b_hdr, 2);
    check("t5_pl_count", n_pl - b_pl, 30);
    check("t5_pl_last_count", n_last - b_last, 1);
    check("t5_pl_last_pos", last_at - b_pl, 30);
    check("t5_trunc_tail", pl_buf[(b_pl + 9) % 1024], 8'h89);
    check("t5_next_first", pl_buf[(b_pl + 10) % 1024], 8'hA0);
    check("t5_err_cleared", err, 1'b0);

    // 6: payload_len == 0 with padding
    make_hdr(4'd5, 16'h0014, 8'h06, 32'h0102_0304, 32'hC0A8_0101);
    fill(20, 4, 8'hEE);
    snap();
    send(24, 3);
    check("t6_hdr_done", n_hdr - b_hdr, 1);
    check("t6_payload_len", payload_len, 16'd0);
    check("t6_sa", sa, 32'h0102_0304);
    check("t6_no_pl", n_pl - b_pl, 0);
    check("t6_no_err", n_err - b_err, 0);

`ifdef IPV4_DA_FILTER_EN
    // 7: destination filter
    make_hdr(4'd5, 16'h0028, 8'h06, 32'hC0A8_0102, 32'hC0A8_0105);
    fill(20, 20, 8'h80);
    snap();
    send(40, 3);
    check("t7_miss_code", code_seen, 3'd7);
    check("t7_miss_no_hdr", n_hdr - b_hdr, 0);
    check("t7_miss_no_pl", n_pl - b_pl, 0);
    make_hdr(4'd5, 16'h0028, 8'h06, 32'hC0A8_0102, 32'hFFFF_FFFF);
    fill(20, 20, 8'h80);
    snap();
    send(40, 3);
    check("t7_bcast_hdr", n_hdr - b_hdr, 1);
    check("t7_bcast_da", da, 32'hFFFF_FFFF);
    check("t7_bcast_no_err", n_err - b_err, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
